// File: rtl/matmul_ctrl_param.sv
// matmul_ctrl_param: parametrised C = A x B sequencer for three single-port memories and a MAC.
// Optional build macro MATMUL_CTRL_PERF_CNT_EN adds the saturating busy-cycle counter port cycle_cnt.
module matmul_ctrl_param #(
   parameter int M_ROWS = 3,
   parameter int K_DIM  = 3,
   parameter int N_COLS = 3,
   parameter int AW     = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          skip_load,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          m1EN,
   output logic          m1rEN,
   output logic          m1wEN,
   output logic          m2EN,
   output logic          m2rEN,
   output logic          m2wEN,
   output logic          m3EN,
   output logic          m3rEN,
   output logic          m3wEN,
   output logic [AW-1:0] addr1,
   output logic [AW-1:0] addr2,
   output logic [AW-1:0] addr3,
   output logic          mult_ld,
   output logic          mult_clr,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy,
   output logic          done
`ifdef MATMUL_CTRL_PERF_CNT_EN
   ,
   output logic [31:0]   cycle_cnt
`endif
);

   typedef enum logic [3:0] {
      IDLE, LOAD_A, LOAD_B, RD, MAC, WB, OUT_RD, OUT_WAIT, DONE
   } state_t;

   localparam logic [AW-1:0] A_LAST = AW'(M_ROWS * K_DIM - 1);
   localparam logic [AW-1:0] B_LAST = AW'(K_DIM * N_COLS - 1);
   localparam logic [AW-1:0] C_LAST = AW'(M_ROWS * N_COLS - 1);
   localparam logic [AW-1:0] M_LAST = AW'(M_ROWS - 1);
   localparam logic [AW-1:0] K_LAST = AW'(K_DIM - 1);
   localparam logic [AW-1:0] N_LAST = AW'(N_COLS - 1);
   localparam logic [AW-1:0] K_W    = AW'(K_DIM);
   localparam logic [AW-1:0] N_W    = AW'(N_COLS);
   localparam logic [AW-1:0] ONE    = AW'(1);

   state_t        state, state_n;
   logic [AW-1:0] idx, idx_n;
   logic [AW-1:0] i, i_n;
   logic [AW-1:0] j, j_n;
   logic [AW-1:0] k, k_n;
   logic [AW-1:0] o, o_n;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         idx   <= '0;
         i     <= '0;
         j     <= '0;
         k     <= '0;
         o     <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         i     <= i_n;
         j     <= j_n;
         k     <= k_n;
         o     <= o_n;
      end
   end

   // Load writes follow in_valid in the same cycle so the shared write-data bus is captured directly.
   always_comb begin
      state_n   = state;
      idx_n     = idx;
      i_n       = i;
      j_n       = j;
      k_n       = k;
      o_n       = o;
      in_ready  = 1'b0;
      m1EN      = 1'b0;
      m1rEN     = 1'b0;
      m1wEN     = 1'b0;
      m2EN      = 1'b0;
      m2rEN     = 1'b0;
      m2wEN     = 1'b0;
      m3EN      = 1'b0;
      m3rEN     = 1'b0;
      m3wEN     = 1'b0;
      addr1     = '0;
      addr2     = '0;
      addr3     = '0;
      mult_ld   = 1'b0;
      mult_clr  = 1'b0;
      out_valid = 1'b0;
      done      = 1'b0;
      busy      = (state != IDLE);

      unique case (state)
         IDLE: begin
            if (start) begin
               idx_n   = '0;
               i_n     = '0;
               j_n     = '0;
               k_n     = '0;
               o_n     = '0;
               state_n = skip_load ? RD : LOAD_A;
            end
         end
         LOAD_A: begin
            in_ready = 1'b1;
            addr1    = idx;
            if (in_valid) begin
               m1EN  = 1'b1;
               m1wEN = 1'b1;
               if (idx == A_LAST) begin
                  idx_n   = '0;
                  state_n = LOAD_B;
               end else begin
                  idx_n = idx + ONE;
               end
            end
         end
         LOAD_B: begin
            in_ready = 1'b1;
            addr2    = idx;
            if (in_valid) begin
               m2EN  = 1'b1;
               m2wEN = 1'b1;
               if (idx == B_LAST) begin
                  idx_n   = '0;
                  state_n = RD;
               end else begin
                  idx_n = idx + ONE;
               end
            end
         end
         RD: begin
            addr1   = i * K_W + k;
            addr2   = k * N_W + j;
            m1EN    = 1'b1;
            m1rEN   = 1'b1;
            m2EN    = 1'b1;
            m2rEN   = 1'b1;
            state_n = MAC;
         end
         MAC: begin
            mult_ld = 1'b1;
            if (k == K_LAST) begin
               k_n     = '0;
               state_n = WB;
            end else begin
               k_n     = k + ONE;
               state_n = RD;
            end
         end
         WB: begin
            m3EN     = 1'b1;
            m3wEN    = 1'b1;
            addr3    = i * N_W + j;
            mult_clr = 1'b1;
            if (j == N_LAST) begin
               j_n = '0;
               if (i == M_LAST) begin
                  i_n     = '0;
                  state_n = OUT_RD;
               end else begin
                  i_n     = i + ONE;
                  state_n = RD;
               end
            end else begin
               j_n     = j + ONE;
               state_n = RD;
            end
         end
         OUT_RD: begin
            m3EN    = 1'b1;
            m3rEN   = 1'b1;
            addr3   = o;
            state_n = OUT_WAIT;
         end
         OUT_WAIT: begin
            out_valid = 1'b1;
            addr3     = o;
            if (out_ready) begin
               if (o == C_LAST) begin
                  o_n     = '0;
                  state_n = DONE;
               end else begin
                  o_n     = o + ONE;
                  state_n = OUT_RD;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

`ifdef MATMUL_CTRL_PERF_CNT_EN
   // Counts busy cycles of the current job; frozen between done and the next start.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cycle_cnt <= '0;
      end else if (state == IDLE && start) begin
         cycle_cnt <= '0;
      end else if (busy && cycle_cnt != 32'hFFFF_FFFF) begin
         cycle_cnt <= cycle_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_matmul_ctrl_param.sv
// tb_matmul_ctrl_param: randomized bench; a 3x3x3 controller drives behavioural memories and a MAC
// checked against a matrix-product model, and a 2x4x3 instance is checked for its address sequences.
`timescale 1ns/1ps
module tb_matmul_ctrl_param;

   localparam int M  = 3, K  = 3, N  = 3, AW  = 8;
   localparam int M2 = 2, K2 = 4, N2 = 3, AW2 = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          start, skip_load, in_valid, in_ready, out_ready;
   logic          m1EN, m1rEN, m1wEN, m2EN, m2rEN, m2wEN, m3EN, m3rEN, m3wEN;
   logic [AW-1:0] addr1, addr2, addr3;
   logic          mult_ld, mult_clr, out_valid, busy, done;
`ifdef MATMUL_CTRL_PERF_CNT_EN
   logic [31:0]   cycle_cnt;
`endif

   logic           start2, in_valid2, in_ready2, out_ready2;
   logic           m1EN2, m1rEN2, m1wEN2, m2EN2, m2rEN2, m2wEN2, m3EN2, m3rEN2, m3wEN2;
   logic [AW2-1:0] addr1_2, addr2_2, addr3_2;
   logic           mult_ld2, mult_clr2, out_valid2, busy2, done2;
`ifdef MATMUL_CTRL_PERF_CNT_EN
   logic [31:0]    cycle_cnt2;
`endif

   matmul_ctrl_param #(.M_ROWS(M), .K_DIM(K), .N_COLS(N), .AW(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .skip_load(skip_load),
      .in_valid(in_valid), .in_ready(in_ready),
      .m1EN(m1EN), .m1rEN(m1rEN), .m1wEN(m1wEN),
      .m2EN(m2EN), .m2rEN(m2rEN), .m2wEN(m2wEN),
      .m3EN(m3EN), .m3rEN(m3rEN), .m3wEN(m3wEN),
      .addr1(addr1), .addr2(addr2), .addr3(addr3),
      .mult_ld(mult_ld), .mult_clr(mult_clr),
      .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done)
`ifdef MATMUL_CTRL_PERF_CNT_EN
      , .cycle_cnt(cycle_cnt)
`endif
   );

   matmul_ctrl_param #(.M_ROWS(M2), .K_DIM(K2), .N_COLS(N2), .AW(AW2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .skip_load(1'b0),
      .in_valid(in_valid2), .in_ready(in_ready2),
      .m1EN(m1EN2), .m1rEN(m1rEN2), .m1wEN(m1wEN2),
      .m2EN(m2EN2), .m2rEN(m2rEN2), .m2wEN(m2wEN2),
      .m3EN(m3EN2), .m3rEN(m3rEN2), .m3wEN(m3wEN2),
      .addr1(addr1_2), .addr2(addr2_2), .addr3(addr3_2),
      .mult_ld(mult_ld2), .mult_clr(mult_clr2),
      .out_valid(out_valid2), .out_ready(out_ready2),
      .busy(busy2), .done(done2)
`ifdef MATMUL_CTRL_PERF_CNT_EN
      , .cycle_cnt(cycle_cnt2)
`endif
   );

   // Behavioural memories with one-cycle read latency and the MAC the controller sequences.
   logic [7:0]  wdata;
   logic [7:0]  memA [0:255];
   logic [7:0]  memB [0:255];
   logic [31:0] memC [0:255];
   logic [7:0]  rdA, rdB;
   logic [31:0] rdC, acc;

   always @(posedge clk) begin
      if (m1EN && m1wEN) memA[addr1] <= wdata;
      if (m1EN && m1rEN) rdA <= memA[addr1];
      if (m2EN && m2wEN) memB[addr2] <= wdata;
      if (m2EN && m2rEN) rdB <= memB[addr2];
      if (m3EN && m3wEN) memC[addr3] <= acc;
      if (m3EN && m3rEN) rdC <= memC[addr3];
      if (!rst || mult_clr) acc <= 32'd0;
      else if (mult_ld)     acc <= acc + 32'(rdA) * 32'(rdB);
   end

   int checks = 0;
   int errors = 0;

   int refA [0:M*K-1];
   int refB [0:K*N-1];
   int refC [0:M*N-1];

   int aWr[$], bWr[$], cWr[$], outAddr[$], outData[$];
   int busyCycles, doneCycles, loadCnt, outCnt, stallCycles, stallAddrBad, writeNoValid;
   bit timedOut;

   // Matrices are row-major; C is the plain triple-loop product.
   task automatic make_matrices(input bit counting);
      for (int r = 0; r < M; r++)
         for (int c = 0; c < K; c++)
            refA[r*K+c] = counting ? r*K + c + 1 : int'($urandom_range(0, 255));
      for (int r = 0; r < K; r++)
         for (int c = 0; c < N; c++)
            refB[r*N+c] = counting ? ((r == c) ? 1 : 0) : int'($urandom_range(0, 255));
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++) begin
            refC[r*N+c] = 0;
            for (int t = 0; t < K; t++) refC[r*N+c] += refA[r*K+t] * refB[t*N+c];
         end
   endtask

   function automatic logic [7:0] loadWord(input int n);
      if (n < M*K)            return 8'(refA[n]);
      else if (n < M*K + K*N) return 8'(refB[n-M*K]);
      else                    return 8'h00;
   endfunction

   task automatic run_job(input bit skip, input bit toggleValid, input int stallWord,
                          input int stallLen, input bit pokeStart);
      int  cyc;
      bit  finished;
      aWr.delete(); bWr.delete(); cWr.delete(); outAddr.delete(); outData.delete();
      busyCycles = 0; doneCycles = 0; loadCnt = 0; outCnt = 0;
      stallCycles = 0; stallAddrBad = 0; writeNoValid = 0;
      start = 1'b1; skip_load = skip;
      @(posedge clk); #1;
      start = 1'b0; skip_load = 1'b0;
      finished = 1'b0; cyc = 0;
      while (!finished && cyc < 3000) begin
         in_valid  = toggleValid ? (cyc % 2 == 0) : 1'b1;
         wdata     = loadWord(loadCnt);
         out_ready = !(outCnt == stallWord && stallCycles < stallLen);
         start     = pokeStart && (cyc % 7 == 3);
         @(negedge clk);
         if (busy) busyCycles++;
         if (done) doneCycles++;
         if ((m1wEN || m2wEN) && !in_valid) writeNoValid++;
         if (m1EN && m1wEN) aWr.push_back(int'(addr1));
         if (m2EN && m2wEN) bWr.push_back(int'(addr2));
         if (m3EN && m3wEN) cWr.push_back(int'(addr3));
         if (in_valid && in_ready) loadCnt++;
         if (out_valid && !out_ready) begin
            stallCycles++;
            if (int'(addr3) != outCnt) stallAddrBad++;
         end
         if (out_valid && out_ready) begin
            outAddr.push_back(int'(addr3));
            outData.push_back(int'(rdC));
            outCnt++;
         end
         if (done) finished = 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      timedOut  = !finished;
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   function automatic int seq_bad(input int q[$], input int len);
      int bad = 0;
      if (q.size() != len) bad++;
      for (int n = 0; n < q.size(); n++) if (q[n] != n) bad++;
      return bad;
   endfunction

   function automatic int data_bad();
      int bad = 0;
      if (outData.size() != M*N) bad++;
      for (int n = 0; n < outData.size() && n < M*N; n++) if (outData[n] != refC[n]) bad++;
      return bad;
   endfunction

   task automatic test_reset();
      logic [14:0] ctl;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      ctl = {in_ready, m1EN, m1rEN, m1wEN, m2EN, m2rEN, m2wEN, m3EN, m3rEN, m3wEN,
             mult_ld, mult_clr, out_valid, busy, done};
      checks++;
      if (ctl !== 15'd0) begin
         errors++; $display("[TB] FAIL reset_ctl: got %b want 0", ctl);
      end
      checks++;
      if ({addr1, addr2, addr3} !== '0) begin
         errors++; $display("[TB] FAIL reset_addr: got %h %h %h want 0", addr1, addr2, addr3);
      end
      checks++;
      if (busy2 !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_busy2: got %b want 0", busy2);
      end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_default();
      int expBusy = M*K + K*N + M*N*(2*K+1) + 2*M*N + 1;
      make_matrices(1'b1);
      run_job(1'b0, 1'b0, -1, 0, 1'b0);
      checks++;
      if (timedOut) begin errors++; $display("[TB] FAIL default_timeout: job never finished"); end
      checks++;
      if (seq_bad(aWr, M*K) != 0) begin
         errors++; $display("[TB] FAIL default_a_addr: %0d writes, want %0d at 0..%0d", aWr.size(), M*K, M*K-1);
      end
      checks++;
      if (seq_bad(bWr, K*N) != 0) begin
         errors++; $display("[TB] FAIL default_b_addr: %0d writes, want %0d at 0..%0d", bWr.size(), K*N, K*N-1);
      end
      checks++;
      if (data_bad() != 0) begin
         errors++; $display("[TB] FAIL default_out_data: %0d bad words of %0d", data_bad(), outData.size());
      end
      checks++;
      if (seq_bad(outAddr, M*N) != 0) begin
         errors++; $display("[TB] FAIL default_out_addr: %0d words streamed, want 0..%0d", outAddr.size(), M*N-1);
      end
      checks++;
      if (seq_bad(cWr, M*N) != 0) begin
         errors++; $display("[TB] FAIL default_c_addr: %0d writes, want 0..%0d", cWr.size(), M*N-1);
      end
      checks++;
      if (doneCycles != 1) begin errors++; $display("[TB] FAIL default_done: %0d cycles want 1", doneCycles); end
      checks++;
      if (busyCycles != expBusy) begin
         errors++; $display("[TB] FAIL default_busy: %0d cycles want %0d", busyCycles, expBusy);
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL default_idle: busy=%b want 0", busy); end
`ifdef MATMUL_CTRL_PERF_CNT_EN
      checks++;
      if (cycle_cnt !== 32'(expBusy)) begin
         errors++; $display("[TB] FAIL default_cycle_cnt: got %0d want %0d", cycle_cnt, expBusy);
      end
`endif
   endtask

   task automatic test_valid_toggle();
      make_matrices(1'b0);
      run_job(1'b0, 1'b1, -1, 0, 1'b0);
      checks++;
      if (timedOut || writeNoValid != 0) begin
         errors++; $display("[TB] FAIL toggle_write_no_valid: %0d writes without in_valid (timeout=%0d)", writeNoValid, timedOut);
      end
      checks++;
      if (seq_bad(aWr, M*K) != 0 || seq_bad(bWr, K*N) != 0) begin
         errors++; $display("[TB] FAIL toggle_addr: A %0d writes B %0d writes, want %0d/%0d in order", aWr.size(), bWr.size(), M*K, K*N);
      end
      checks++;
      if (data_bad() != 0) begin
         errors++; $display("[TB] FAIL toggle_out_data: %0d bad words", data_bad());
      end
   endtask

   task automatic test_out_stall();
      int expBusy = M*K + K*N + M*N*(2*K+1) + 2*M*N + 1 + 5;
      make_matrices(1'b0);
      run_job(1'b0, 1'b0, 4, 5, 1'b0);
      checks++;
      if (stallCycles != 5 || stallAddrBad != 0) begin
         errors++; $display("[TB] FAIL stall_hold: %0d stalled cycles, %0d with moved addr3; want 5 and 0", stallCycles, stallAddrBad);
      end
      checks++;
      if (seq_bad(outAddr, M*N) != 0) begin
         errors++; $display("[TB] FAIL stall_out_addr: %0d words streamed, want %0d distinct in order", outAddr.size(), M*N);
      end
      checks++;
      if (data_bad() != 0) begin errors++; $display("[TB] FAIL stall_out_data: %0d bad words", data_bad()); end
      checks++;
      if (busyCycles != expBusy) begin
         errors++; $display("[TB] FAIL stall_busy: %0d cycles want %0d", busyCycles, expBusy);
      end
   endtask

   task automatic test_skip_load();
      int prev[$];
      int diff = 0;
      int expBusy = M*N*(2*K+1) + 2*M*N + 1;
      prev = outData;
      run_job(1'b1, 1'b0, -1, 0, 1'b1);
      checks++;
      if (aWr.size() != 0 || bWr.size() != 0) begin
         errors++; $display("[TB] FAIL skip_writes: A %0d B %0d writes want 0", aWr.size(), bWr.size());
      end
      checks++;
      if (data_bad() != 0) begin errors++; $display("[TB] FAIL skip_out_data: %0d bad words", data_bad()); end
      for (int n = 0; n < prev.size() && n < outData.size(); n++) if (prev[n] != outData[n]) diff++;
      checks++;
      if (diff != 0 || prev.size() != outData.size()) begin
         errors++; $display("[TB] FAIL skip_same_result: %0d differing words, sizes %0d/%0d", diff, outData.size(), prev.size());
      end
      checks++;
      if (busyCycles != expBusy || doneCycles != 1) begin
         errors++; $display("[TB] FAIL skip_busy: %0d busy %0d done, want %0d and 1", busyCycles, doneCycles, expBusy);
      end
   endtask

   task automatic test_reset_mid();
      int lds = 0;
      int cyc = 0;
      logic [14:0] ctl;
      start = 1'b1; skip_load = 1'b0; in_valid = 1'b1; out_ready = 1'b1; wdata = 8'h00;
      @(posedge clk); #1;
      start = 1'b0;
      while (lds < 5 && cyc < 400) begin
         @(negedge clk);
         if (mult_ld) lds++;
         if (lds < 5) begin @(posedge clk); #1; end
         cyc++;
      end
      checks++;
      if (lds < 5) begin errors++; $display("[TB] FAIL midreset_reach_mac: %0d mult_ld pulses want 5", lds); end
      rst = 1'b0;
      @(posedge clk); #1;
      ctl = {in_ready, m1EN, m1rEN, m1wEN, m2EN, m2rEN, m2wEN, m3EN, m3rEN, m3wEN,
             mult_ld, mult_clr, out_valid, busy, done};
      checks++;
      if (ctl !== 15'd0 || {addr1, addr2, addr3} !== '0) begin
         errors++; $display("[TB] FAIL midreset_outputs: ctl %b addr %h %h %h want all 0", ctl, addr1, addr2, addr3);
      end
      rst = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      make_matrices(1'b0);
      run_job(1'b0, 1'b0, -1, 0, 1'b0);
      checks++;
      if (timedOut || data_bad() != 0 || seq_bad(aWr, M*K) != 0) begin
         errors++; $display("[TB] FAIL midreset_rerun: %0d bad words, %0d A writes (timeout=%0d)", data_bad(), aWr.size(), timedOut);
      end
   endtask

   task automatic test_shape();
      int a2[$], b2[$], c2[$], o2[$], ldPer[$];
      int ldRun = 0, ldBad = 0, dones = 0, cyc = 0;
      bit finished = 1'b0;
      start2 = 1'b1; in_valid2 = 1'b1; out_ready2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      while (!finished && cyc < 2000) begin
         @(negedge clk);
         if (m1EN2 && m1wEN2) a2.push_back(int'(addr1_2));
         if (m2EN2 && m2wEN2) b2.push_back(int'(addr2_2));
         if (mult_ld2) ldRun++;
         if (m3EN2 && m3wEN2) begin c2.push_back(int'(addr3_2)); ldPer.push_back(ldRun); ldRun = 0; end
         if (out_valid2 && out_ready2) o2.push_back(int'(addr3_2));
         if (done2) begin dones++; finished = 1'b1; end
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (a2.size() != M2*K2 || seq_bad(a2, M2*K2) != 0) begin
         errors++; $display("[TB] FAIL shape_a_addr: %0d writes last %0d, want %0d ending at %0d",
                            a2.size(), (a2.size() > 0) ? a2[$] : -1, M2*K2, M2*K2-1);
      end
      checks++;
      if (b2.size() != K2*N2 || seq_bad(b2, K2*N2) != 0) begin
         errors++; $display("[TB] FAIL shape_b_addr: %0d writes last %0d, want %0d ending at %0d",
                            b2.size(), (b2.size() > 0) ? b2[$] : -1, K2*N2, K2*N2-1);
      end
      checks++;
      if (seq_bad(c2, M2*N2) != 0) begin
         errors++; $display("[TB] FAIL shape_c_addr: %0d writes, want 0..%0d in order", c2.size(), M2*N2-1);
      end
      foreach (ldPer[n]) if (ldPer[n] != K2) ldBad++;
      checks++;
      if (ldBad != 0 || ldPer.size() != M2*N2) begin
         errors++; $display("[TB] FAIL shape_mult_ld: %0d C writes with wrong pulse count, want %0d pulses each", ldBad, K2);
      end
      checks++;
      if (seq_bad(o2, M2*N2) != 0 || dones != 1) begin
         errors++; $display("[TB] FAIL shape_out: %0d words %0d done, want %0d and 1", o2.size(), dones, M2*N2);
      end
      in_valid2 = 1'b0; out_ready2 = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; skip_load = 1'b0; in_valid = 1'b0; out_ready = 1'b0; wdata = 8'h00;
      start2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0;
      test_reset();
      test_default();
      test_valid_toggle();
      test_out_stall();
      test_skip_load();
      test_reset_mid();
      test_shape();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
